imm_sign_extend: RTL and testbench
==================================

# imm_sign_extend

Immediate generator for the single-cycle RISC-V (RV32I) core. It takes the immediate-carrying instruction field `instr[31:7]` and the decoder's `imm_src` selector. It reassembles the I/S/B/J/U immediate and sign-extends it to 32 bits. The result is presented registered to the ALU-operand and branch-target muxes.

## Interface
Parameters:
- None. Width is fixed: XLEN = 32.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  Rising-edge clock.
- `rst_n`  in  1  Reset. Synchronous, active-low.
- `in_valid`  in  1  Qualifies `imm_src` and `instr` this cycle.
- `imm_src`  in  3  Format select:
  - 0 = I
  - 1 = S
  - 2 = B
  - 3 = J
  - 4 = U
  - 5–7 = illegal
- `instr`  in  25 (bits [31:7])  Instruction word with the opcode stripped. Indexed by the true instruction bit positions 31..7.
- `imm_ext`  out  32  Sign-extended immediate (registered).
- `imm_valid`  out  1  `imm_ext` is valid (registered copy of `in_valid`).
- `imm_illegal`  out  1  Registered flag: `imm_src` was 5–7 while `in_valid` was high.

## Operation
Combinational next value, where `s` = `instr[31]`:
- I: `{20{s}}, instr[31:20]`
- S: `{20{s}}, instr[31:25], instr[11:7]`
- B: `{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0`. Bit 0 is always 0.
- J: `{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0`. Bit 0 is always 0.
- U: `instr[31:12], 12'b0`. No extension; the low 12 bits are 0.
- `imm_src` 5–7: next value is 0x00000000 and `imm_illegal` is set.

General rules:
- Pure bit-selection and replication; no arithmetic, so overflow is not possible.
- Sign bit is always `instr[31]` for every format.
- When `in_valid` is 0:
  - `imm_ext` holds its previous value.
  - `imm_valid` becomes 0.
  - `imm_illegal` becomes 0.
- Bits outside the selected format's field are don't-care. They must not affect the output; for example, I-type ignores `instr[19:7]`.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Throughput: one immediate per cycle, with no stall or back-pressure.
- Reset:
  - On any edge with `rst_n`=0: `imm_ext` = 0x00000000, `imm_valid` = 0, `imm_illegal` = 0.
  - Reset overrides `in_valid`.
  - The first valid output appears one cycle after the first qualified input following reset release.
- A format change between back-to-back valid cycles takes effect on the very next output. There is no extra bubble.
- Reset asserted mid-stream discards the in-flight value. No partial output.

## Structure
- Shared package `riscv_pkg` holds:
  - `imm_src` encoding constants: `IMM_I`=3'd0, `IMM_S`=3'd1, `IMM_B`=3'd2, `IMM_J`=3'd3, `IMM_U`=3'd4.
  - `XLEN` = 32.
- The decoder imports the same constants.
- One natural sub-module, `imm_sign_extend_comb`:
  - The purely combinational format mux (case on `imm_src`).
  - Wrapped by the registered top.
  - Reusable by the single-cycle datapath without the register stage.

## Test plan
- Ones sweep:
  - Input: `instr` all ones; `imm_src` 0, 1, 2, 3, 4 on consecutive cycles.
  - Required output: 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFE, 0xFFFFF000 (one per cycle, 1-cycle latency).
- Positive I and S:
  - Input: I instruction 0x7FF00093 (`addi x1,x0,2047`) → required output 0x000007FF.
  - Input: S instruction 0x0020A423 (`sw x2,8(x1)`) → required output 0x00000008.
- Negative B and J:
  - Input: B instruction 0xFE000EE3 (`beq x0,x0,-4`) → required output 0xFFFFFFFC.
  - Input: J instruction 0xFFDFF0EF (`jal x1,-4`) → required output 0xFFFFFFFC.
- U-type:
  - Input: 0x123450B7 (`lui x1,0x12345`) → required output 0x12345000.
  - Input: all ones → required output 0xFFFFF000.
- Illegal and hold:
  - Input: `imm_src`=6 with `in_valid`=1 → required output `imm_ext`=0, `imm_illegal`=1.
  - Input: then `in_valid`=0 → required output `imm_ext` holds, `imm_valid`=0, `imm_illegal`=0.
- Reset:
  - Input: assert `rst_n`=0 while streaming valid inputs → required output all outputs 0 on the next edge.
  - Input: release reset → required output first valid result one cycle after the next qualified input.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: XLEN and the imm_src format encoding used by
// the decoder and the immediate generator.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // Any selector above IMM_U has no defined immediate format.
  function automatic logic imm_src_illegal(input logic [2:0] src);
    return (src > IMM_U);
  endfunction

endpackage

// File: rtl/imm_sign_extend_comb.sv
// Combinational RV32I immediate reassembly and sign extension; usable
// directly by a single-cycle datapath without the register stage.
module imm_sign_extend_comb
  import riscv_pkg::*;
(
  input  logic [2:0]      imm_src,
  input  logic [31:7]     instr,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic s;
  assign s = instr[31];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: imm = {{20{s}}, instr[31:20]};
      IMM_S: imm = {{20{s}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_sign_extend.sv
// Registered immediate generator: one-cycle latency, holds the last
// immediate while in_valid is low, flags illegal format selectors.
module imm_sign_extend
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [2:0]      imm_src,
  input  logic [31:7]     instr,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_valid,
  output logic            imm_illegal
);

  logic [XLEN-1:0] comb_imm;
  logic            comb_illegal;

  logic [XLEN-1:0] imm_ext_d,     imm_ext_q;
  logic            imm_valid_d,   imm_valid_q;
  logic            imm_illegal_d, imm_illegal_q;

  imm_sign_extend_comb u_comb (
    .imm_src (imm_src),
    .instr   (instr),
    .imm     (comb_imm),
    .illegal (comb_illegal)
  );

  // Unqualified cycles keep the immediate so downstream muxes stay stable.
  always_comb begin
    imm_ext_d     = imm_ext_q;
    imm_valid_d   = in_valid;
    imm_illegal_d = in_valid & comb_illegal;
    if (in_valid) begin
      imm_ext_d = comb_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_ext_q     <= '0;
      imm_valid_q   <= 1'b0;
      imm_illegal_q <= 1'b0;
    end else begin
      imm_ext_q     <= imm_ext_d;
      imm_valid_q   <= imm_valid_d;
      imm_illegal_q <= imm_illegal_d;
    end
  end

  assign imm_ext     = imm_ext_q;
  assign imm_valid   = imm_valid_q;
  assign imm_illegal = imm_illegal_q;

endmodule

// File: tb/tb_imm_sign_extend.sv
// Self-checking bench for imm_sign_extend: directed RV32I encodings plus
// random streams, checked through an expected-result queue.
module tb_imm_sign_extend;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  imm_src;
  logic [31:7] instr;
  logic [31:0] imm_ext;
  logic        imm_valid;
  logic        imm_illegal;

  logic [33:0] exp_q[$];
  logic [31:0] held_ext;
  int          n_checks;
  int          n_errors;

  imm_sign_extend dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .imm_src     (imm_src),
    .instr       (instr),
    .imm_ext     (imm_ext),
    .imm_valid   (imm_valid),
    .imm_illegal (imm_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model built from the format tables via signed extension.
  function automatic logic [31:0] ref_imm(input logic [2:0] src, input logic [31:0] w);
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    case (src)
      3'd0: begin i12 = w[31:20];             return 32'($signed(i12)); end
      3'd1: begin i12 = {w[31:25], w[11:7]};  return 32'($signed(i12)); end
      3'd2: begin
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        return 32'($signed(b13));
      end
      3'd3: begin
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return 32'($signed(j21));
      end
      3'd4:    return {w[31:12], 12'h000};
      default: return 32'h0;
    endcase
  endfunction

  // Drives one cycle, queues the expected outputs, then compares after the edge.
  task automatic step(input string tag, input logic rn, input logic v, input logic [2:0] src,
                      input logic [31:0] w, input logic use_const, input logic [31:0] const_ext);
    logic [31:0] e_ext;
    logic        e_vld;
    logic        e_ill;
    logic [33:0] e;
    @(negedge clk);
    rst_n    = rn;
    in_valid = v;
    imm_src  = src;
    instr    = w[31:7];
    if (!rn) begin
      e_ext = 32'h0; e_vld = 1'b0; e_ill = 1'b0;
    end else if (v) begin
      e_ext = use_const ? const_ext : ref_imm(src, w);
      e_vld = 1'b1;
      e_ill = (src > 3'd4);
    end else begin
      e_ext = held_ext; e_vld = 1'b0; e_ill = 1'b0;
    end
    held_ext = e_ext;
    exp_q.push_back({e_ill, e_vld, e_ext});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".ext"},     imm_ext,             e[31:0]);
    check({tag, ".valid"},   {31'b0, imm_valid},   {31'b0, e[32]});
    check({tag, ".illegal"}, {31'b0, imm_illegal}, {31'b0, e[33]});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    held_ext = 32'h0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    imm_src  = 3'd0;
    instr    = '0;

    step("reset0", 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0);
    step("reset1", 1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    step("idle",   1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0);

    step("ones_I", 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    step("ones_S", 1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    step("ones_B", 1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    step("ones_J", 1'b1, 1'b1, 3'd3, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    step("ones_U", 1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_F000);

    step("addi",   1'b1, 1'b1, 3'd0, 32'h7FF0_0093, 1'b1, 32'h0000_07FF);
    step("sw",     1'b1, 1'b1, 3'd1, 32'h0020_A423, 1'b1, 32'h0000_0008);
    step("beq",    1'b1, 1'b1, 3'd2, 32'hFE00_0EE3, 1'b1, 32'hFFFF_FFFC);
    step("jal",    1'b1, 1'b1, 3'd3, 32'hFFDF_F0EF, 1'b1, 32'hFFFF_FFFC);
    step("lui",    1'b1, 1'b1, 3'd4, 32'h1234_50B7, 1'b1, 32'h1234_5000);
    step("I_dc",   1'b1, 1'b1, 3'd0, 32'h0000_0FFF, 1'b1, 32'h0000_0000);

    step("ill6",   1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
    step("lui2",   1'b1, 1'b1, 3'd4, 32'h1234_50B7, 1'b1, 32'h1234_5000);
    step("hold",   1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF, 1'b1, 32'h0);
    step("hold2",  1'b1, 1'b0, 3'd2, 32'h0000_0000, 1'b1, 32'h0);
    step("ill7",   1'b1, 1'b1, 3'd7, 32'h8000_0000, 1'b1, 32'h0000_0000);
    step("ill5",   1'b1, 1'b1, 3'd5, 32'h1234_5678, 1'b1, 32'h0000_0000);

    step("pre_rst", 1'b1, 1'b1, 3'd3, 32'hFFDF_F0EF, 1'b1, 32'hFFFF_FFFC);
    step("mid_rst", 1'b0, 1'b1, 3'd0, 32'h7FF0_0093, 1'b1, 32'h0);
    step("rel_idl", 1'b1, 1'b0, 3'd0, 32'h7FF0_0093, 1'b1, 32'h0);
    step("rel_1st", 1'b1, 1'b1, 3'd0, 32'h7FF0_0093, 1'b1, 32'h0000_07FF);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] w;
      logic [2:0]  src;
      logic        v;
      logic        rn;
      w   = $urandom();
      src = 3'($urandom_range(0, 7));
      v   = ($urandom_range(0, 3) != 0);
      rn  = ($urandom_range(0, 29) != 0);
      step("rand", rn, v, src, w, 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
